uart_sif_arb: RTL

- Round-robin arbiter sharing the single simple-interface (sif) register port of the UART core between NREQ requesters, e.g. a CPU-side bridge and a DMA/test sequencer.
- Sits between the requesters and the UART sif slave.
- Serialises one read or write at a time, registers all slave-side signals, and returns read data with a one-cycle acknowledge to the winning requester.

---
 rtl/uart_sif_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_sif_arb.sv
// uart_sif_arb: round-robin arbiter that shares the UART sif register port
// between NREQ requesters. One transaction at a time is serialised through
// IDLE -> ISSUE -> WAIT -> ACK. All slave-side signals are registered, and
// read data goes back with a one-cycle acknowledge.
module uart_sif_arb #(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_re,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wd,
  output logic [NREQ*DW-1:0]   req_rd,
  output logic [NREQ-1:0]      req_ack,
  output logic [AW-1:0]        s_addr,
  output logic                 s_re,
  output logic                 s_we,
  output logic [DW-1:0]        s_wd,
  input  logic [DW-1:0]        s_rd
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic                rd_op_q, rd_op_d;
  logic [AW-1:0]       s_addr_q, s_addr_d;
  logic [DW-1:0]       s_wd_q, s_wd_d;
  logic                s_re_q, s_re_d;
  logic                s_we_q, s_we_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ*DW-1:0]  rd_q, rd_d;

  logic [NREQ-1:0]     active;
  logic                sel_found;
  logic [GW-1:0]       sel_idx;

  assign active = req_re | req_we;

  // Round-robin pick: first active requester scanning upward from the pointer with wrap.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!sel_found && active[idx]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  // Next-state logic; strobes and ack default low so each is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    rd_op_d  = rd_op_q;
    s_addr_d = s_addr_q;
    s_wd_d   = s_wd_q;
    s_re_d   = 1'b0;
    s_we_d   = 1'b0;
    ack_d    = '0;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d  = sel_idx;
          s_addr_d = req_addr[sel_idx*AW +: AW];
          s_wd_d   = req_wd[sel_idx*DW +: DW];
          // A write wins when both strobes are requested; the read is dropped.
          s_we_d   = req_we[sel_idx];
          s_re_d   = req_re[sel_idx] & ~req_we[sel_idx];
          rd_op_d  = req_re[sel_idx] & ~req_we[sel_idx];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Slave read data is valid in this cycle; only the winner's slice changes.
        if (rd_op_q) begin
          rd_d[grant_q*DW +: DW] = s_rd;
        end
        ack_d[grant_q] = 1'b1;
        state_d        = ST_ACK;
      end
      ST_ACK: begin
        ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      rd_op_q  <= 1'b0;
      s_addr_q <= '0;
      s_wd_q   <= '0;
      s_re_q   <= 1'b0;
      s_we_q   <= 1'b0;
      ack_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      rd_op_q  <= rd_op_d;
      s_addr_q <= s_addr_d;
      s_wd_q   <= s_wd_d;
      s_re_q   <= s_re_d;
      s_we_q   <= s_we_d;
      ack_q    <= ack_d;
      rd_q     <= rd_d;
    end
  end

  assign s_addr  = s_addr_q;
  assign s_wd    = s_wd_q;
  assign s_re    = s_re_q;
  assign s_we    = s_we_q;
  assign req_ack = ack_q;
  assign req_rd  = rd_q;

endmodule
